alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
  parameter int DATA_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [3:0]              req_op,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic                    rsp_zero,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [1:0]              alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  output logic                    busy,
  output logic [7:0]              op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                state_q;
  logic                  owner_q, last_q, rsp_zero_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [1:0]            alu_op_q;
  logic [7:0]            op_count_q;
  logic                  gnt_vld, gnt_idx;
  // grant only from IDLE; on contention the requester that did not win last time goes first
  always_comb begin
    gnt_vld = rst_n && state_q == IDLE && |req_valid;
    gnt_idx = &req_valid ? ~last_q : req_valid[1];
  end
  assign req_ready  = gnt_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid  = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = state_q != IDLE;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign op_count   = op_count_q;
  // operation sequencing: load operands, capture ALU output one cycle later, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          owner_q  <= gnt_idx;
          alu_op_q <= gnt_idx ? req_op[3:2] : req_op[1:0];
          alu_a_q  <= gnt_idx ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
          alu_b_q  <= gnt_idx ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
          state_q  <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          state_q      <= RESP;
        end
        RESP: if (rsp_ready[owner_q]) begin
          last_q     <= owner_q;
          op_count_q <= op_count_q + 8'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
